// File: rtl/mdu_pkg.sv
// Shared types and constants for the multi-cycle MULTU/DIVU sequencer.
package mdu_pkg;

  localparam int DATA_W = 32;
  localparam int ITERS  = DATA_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_DONE
  } state_e;

  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

endpackage

// File: rtl/mdu_step.sv
// One iteration of shift-and-add multiply or restoring divide, built around
// the external add/sub ALU; purely combinational.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             op_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] m_i,
  input  logic [WIDTH-1:0] alu_result_i,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic             alu_bneg_o,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] shifted;
  logic             carry;
  logic             ok;

  assign shifted = {acc_i[WIDTH-2:0], q_i[WIDTH-1]};

  always_comb begin
    alu_a_o    = '0;
    alu_b_o    = '0;
    alu_bneg_o = 1'b0;
    acc_o      = acc_i;
    q_o        = q_i;
    carry      = 1'b0;
    ok         = 1'b0;
    if (op_i == OP_MULTU) begin
      alu_a_o    = acc_i;
      alu_b_o    = q_i[0] ? m_i : '0;
      alu_bneg_o = 1'b0;
      // The ALU has no carry-out; a wrapped sum is smaller than either addend.
      carry      = (alu_result_i < acc_i);
      acc_o      = {carry, alu_result_i[WIDTH-1:1]};
      q_o        = {alu_result_i[0], q_i[WIDTH-1:1]};
    end else begin
      alu_a_o    = shifted;
      alu_b_o    = m_i;
      alu_bneg_o = 1'b1;
      // A set MSB in rem means the shifted value exceeds WIDTH bits, so it always covers d.
      ok         = acc_i[WIDTH-1] | (shifted >= m_i);
      acc_o      = ok ? alu_result_i : shifted;
      q_o        = {q_i[WIDTH-2:0], ok};
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MULTU/DIVU sequencer that borrows the EX-stage ALU for
// one add or subtract per cycle and publishes results to HI/LO.
module alu_muldiv_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             flush,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_bneg,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             op_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             dbz_q;
  logic             done_q;

  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] step_a;
  logic [WIDTH-1:0] step_b;
  logic             step_bneg;
  logic             last_step;

  mdu_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .op_i        (op_q),
    .acc_i       (acc_q),
    .q_i         (q_q),
    .m_i         (m_q),
    .alu_result_i(alu_result),
    .alu_a_o     (step_a),
    .alu_b_o     (step_b),
    .alu_bneg_o  (step_bneg),
    .acc_o       (acc_d),
    .q_o         (q_d)
  );

  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  // The ALU is only borrowed while iterating; otherwise it sees a quiet 0+0.
  assign alu_a    = (state_q == S_ITER) ? step_a : '0;
  assign alu_b    = (state_q == S_ITER) ? step_b : '0;
  assign alu_bneg = (state_q == S_ITER) ? step_bneg : 1'b0;

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign dbz  = dbz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULTU;
      acc_q   <= '0;
      q_q     <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start && !flush) begin
            state_q <= S_ITER;
            cnt_q   <= '0;
            op_q    <= op;
            acc_q   <= '0;
            q_q     <= opa;
            m_q     <= opb;
          end
        end
        S_ITER: begin
          // flush beats completion: a flushed last step publishes nothing.
          if (flush) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else begin
            acc_q <= acc_d;
            q_q   <= q_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_step) begin
              state_q <= S_DONE;
              cnt_q   <= '0;
              done_q  <= 1'b1;
              hi_q    <= acc_d;
              lo_q    <= q_d;
              dbz_q   <= (op_q == OP_DIVU) && (m_q == '0);
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
